fifo_uart_tx: RTL and testbench

//  Drain stage directly downstream of the 16x8 FIFO memory: pops bytes from the FIFO read

---
 rtl/fifo_uart_tx_pkg.sv | 20 ++
 rtl/fifo_uart_tx_if.sv | 15 +
 rtl/fifo_uart_tx_baud_gen.sv | 33 +++
 rtl/fifo_uart_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: FSM state encoding,
// frame geometry and the parity helper.
package fifo_uart_tx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit for one byte: even parity when odd=0, odd parity when odd=1.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the 16x8 FIFO and its UART drain stage.
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO data_out, valid whenever fifo_empty=0
//   fifo_rd    : pop strobe, one clk per byte
// master = the reader (UART drain), slave = the FIFO.
interface fifo_uart_tx_if;
  import fifo_uart_tx_pkg::*;

  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_rd;

  modport master (input fifo_empty, input fifo_data, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the bit period (counter to 0 on the next edge)
//   bit_end  : high on cycle CLKS_PER_BIT-1 of each bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_LAST);

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain stage behind the 16x8 FIFO: pops a byte whenever the FIFO is non-empty
// and en=1, and serialises it as a UART frame (start, 8 data LSB first,
// optional parity, 1 or 2 stop bits). Frames run back-to-back while data remains.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : permit starting new frames (an in-flight frame always completes)
//   fifo       : FIFO read port (master side: drives fifo_rd)
//   tx         : registered serial output, idles high
//   busy       : high from START through the last stop-bit cycle
//   frame_done : one-cycle pulse after the last stop-bit cycle of each frame
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  state_t                    state, state_nxt;
  logic [UART_DATA_BITS-1:0] shift, shift_nxt;
  logic [2:0]                bit_idx, bit_idx_nxt;
  logic                      stop_idx, stop_idx_nxt;
  logic                      tx_nxt, busy_nxt, done_nxt;
  logic                      bit_end, last_stop, pop;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (pop),
    .bit_end (bit_end)
  );

  assign last_stop = (state == ST_STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));

  // Pop is combinational so the next frame can start on the very edge that
  // ends the previous one; gated by rst so a held reset never drains the FIFO.
  assign pop          = ~rst & en & ~fifo.fifo_empty & ((state == ST_IDLE) | last_stop);
  assign fifo.fifo_rd = pop;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    tx_nxt       = tx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          tx_nxt    = shift[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            bit_idx_nxt  = 3'd0;
            stop_idx_nxt = 1'b0;
            if (PARITY_EN != 0) begin
              state_nxt = ST_PARITY;
              tx_nxt    = parity_bit(shift, PARITY_ODD != 0);
            end else begin
              state_nxt = ST_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = shift[bit_idx + 3'd1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt    = ST_STOP;
          stop_idx_nxt = 1'b0;
          tx_nxt       = 1'b1;
        end
      end
      ST_STOP: begin
        if (last_stop) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          tx_nxt    = 1'b1;
          done_nxt  = 1'b1;
        end else if (bit_end) begin
          stop_idx_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase

    // A pop overrides the idle/stop exit: start bit goes out on this same edge.
    // frame_done from a finishing frame is kept.
    if (pop) begin
      state_nxt    = ST_START;
      shift_nxt    = fifo.fifo_data;
      bit_idx_nxt  = 3'd0;
      stop_idx_nxt = 1'b0;
      tx_nxt       = 1'b0;
      busy_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_idx    <= 3'd0;
      stop_idx   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bit_idx    <= bit_idx_nxt;
      stop_idx   <= stop_idx_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx. Two instances share clk/rst/en:
//   dut_a : CLKS_PER_BIT=4, no parity, 1 stop bit  (40-clk frames)
//   dut_b : CLKS_PER_BIT=4, odd parity, 2 stop bits (48-clk frames)
// Each is fed by a small behavioural 16-deep FIFO that counts pops and underflows.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_uart_tx_if ifa ();
  fifo_uart_tx_if ifb ();

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .fifo(ifa.master),
    .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .fifo(ifb.master),
    .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  // ---------------- behavioural FIFO models (not reset by rst) ----------------
  logic [7:0] mem [2][16];
  int         wp [2];
  int         rp [2];
  int         cnt [2];
  int         pops [2];
  int         underflow [2];
  logic       push [2];
  logic [7:0] pdata [2];
  logic       rd [2];

  assign rd[0] = ifa.fifo_rd;
  assign rd[1] = ifb.fifo_rd;
  assign ifa.fifo_empty = (cnt[0] == 0);
  assign ifb.fifo_empty = (cnt[1] == 0);
  assign ifa.fifo_data  = mem[0][rp[0]];
  assign ifb.fifo_data  = mem[1][rp[1]];

  initial begin
    for (int i = 0; i < 2; i++) begin
      wp[i] = 0; rp[i] = 0; cnt[i] = 0; pops[i] = 0; underflow[i] = 0;
      push[i] = 1'b0; pdata[i] = 8'h00;
      for (int j = 0; j < 16; j++) mem[i][j] = 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem[i][wp[i]] <= pdata[i];
        wp[i]         <= (wp[i] + 1) % 16;
      end
      if (rd[i] && cnt[i] == 0) underflow[i] <= underflow[i] + 1;
      if (rd[i] && cnt[i] != 0) begin
        rp[i]   <= (rp[i] + 1) % 16;
        pops[i] <= pops[i] + 1;
      end
      cnt[i] <= cnt[i] + (push[i] ? 1 : 0) - ((rd[i] && cnt[i] != 0) ? 1 : 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic push_byte(input int which, input logic [7:0] data);
    @(negedge clk);
    push[which]  = 1'b1;
    pdata[which] = data;
    @(negedge clk);
    push[which]  = 1'b0;
  endtask

  // Called in the low phase just before the pop edge. Checks every cycle of the
  // frame and returns at the negedge inside the last stop-bit cycle.
  task automatic run_frame(input int which, input logic [7:0] data, input logic prev_done,
                           input int drop_en_at, input string name);
    logic exp_bits [16];
    int   nb, len, p0;
    logic t, b, d;
    nb = 0;
    exp_bits[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin exp_bits[nb] = data[i]; nb++; end
    if (which == 1) begin exp_bits[nb] = (^data) ^ 1'b1; nb++; end
    exp_bits[nb] = 1'b1; nb++;
    if (which == 1) begin exp_bits[nb] = 1'b1; nb++; end
    len = nb * 4;
    p0  = pops[which];
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      t = (which == 1) ? tx_b   : tx_a;
      b = (which == 1) ? busy_b : busy_a;
      d = (which == 1) ? done_b : done_a;
      if (c == 0) begin
        n_cmp++;
        if (pops[which] !== p0 + 1) begin
          n_bad++; $display("FAIL %s pop_count got=%0d want=%0d", name, pops[which], p0 + 1);
        end
      end
      n_cmp++;
      if (t !== exp_bits[c / 4]) begin
        n_bad++; $display("FAIL %s tx clk=%0d got=%b want=%b", name, c, t, exp_bits[c / 4]);
      end
      n_cmp++;
      if (b !== 1'b1) begin
        n_bad++; $display("FAIL %s busy clk=%0d got=%b want=1", name, c, b);
      end
      n_cmp++;
      if (d !== ((c == 0) ? prev_done : 1'b0)) begin
        n_bad++; $display("FAIL %s frame_done clk=%0d got=%b want=%b", name, c, d,
                          (c == 0) ? prev_done : 1'b0);
      end
      if (c == drop_en_at) en = 1'b0;
    end
  endtask

  // Negedge after the last stop-bit cycle of dut_a with nothing following.
  task automatic expect_done_a(input string name);
    @(negedge clk);
    n_cmp++;
    if (done_a !== 1'b1) begin n_bad++; $display("FAIL %s frame_done got=%b want=1", name, done_a); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL %s busy_end got=%b want=0", name, busy_a); end
    n_cmp++;
    if (tx_a !== 1'b1) begin n_bad++; $display("FAIL %s tx_idle got=%b want=1", name, tx_a); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    push_byte(0, 8'hA5);          // queued while rst is held
    #1;
    n_cmp++;
    if (ifa.fifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset fifo_rd got=%b want=0", ifa.fifo_rd); end
    n_cmp++;
    if (tx_a !== 1'b1) begin n_bad++; $display("FAIL reset tx got=%b want=1", tx_a); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset busy got=%b want=0", busy_a); end
    n_cmp++;
    if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset frame_done got=%b want=0", done_a); end
    n_cmp++;
    if (pops[0] !== 0) begin n_bad++; $display("FAIL reset pops got=%0d want=0", pops[0]); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ifa.fifo_rd !== 1'b1) begin n_bad++; $display("FAIL reset_release fifo_rd got=%b want=1", ifa.fifo_rd); end
    n_cmp++;
    if (ifb.fifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset_release empty_b fifo_rd got=%b want=0", ifb.fifo_rd); end
  endtask

  task automatic test_single_byte();
    run_frame(0, 8'hA5, 1'b0, -1, "single_a5");
    #1;
    n_cmp++;
    if (ifa.fifo_rd !== 1'b0) begin n_bad++; $display("FAIL single_a5 no_second_pop got=%b want=0", ifa.fifo_rd); end
    expect_done_a("single_a5");
    n_cmp++;
    if (pops[0] !== 1) begin n_bad++; $display("FAIL single_a5 total_pops got=%0d want=1", pops[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    int p0;
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
    en = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(0, seq[i]);
    p0 = pops[0];
    en = 1'b1;
    #1;
    n_cmp++;
    if (ifa.fifo_rd !== 1'b1) begin n_bad++; $display("FAIL b2b first_pop got=%b want=1", ifa.fifo_rd); end
    for (int i = 0; i < 3; i++) begin
      run_frame(0, seq[i], (i != 0), -1, $sformatf("b2b_frame%0d", i));
      #1;
      n_cmp++;
      if (ifa.fifo_rd !== (i < 2)) begin
        n_bad++; $display("FAIL b2b pop_at_stop%0d got=%b want=%b", i, ifa.fifo_rd, (i < 2));
      end
    end
    n_cmp++;
    if (ifa.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL b2b empty got=%b want=1", ifa.fifo_empty); end
    expect_done_a("b2b");
    n_cmp++;
    if (pops[0] - p0 !== 3) begin n_bad++; $display("FAIL b2b pops got=%0d want=3", pops[0] - p0); end
    n_cmp++;
    if (underflow[0] !== 0) begin n_bad++; $display("FAIL b2b underflow got=%0d want=0", underflow[0]); end
  endtask

  task automatic test_parity_two_stop();
    push_byte(1, 8'h07);
    #1;
    n_cmp++;
    if (ifb.fifo_rd !== 1'b1) begin n_bad++; $display("FAIL parity pop got=%b want=1", ifb.fifo_rd); end
    run_frame(1, 8'h07, 1'b0, -1, "parity_07");   // parity bit expected 0, 48 clks
    @(negedge clk);
    n_cmp++;
    if (done_b !== 1'b1) begin n_bad++; $display("FAIL parity frame_done got=%b want=1", done_b); end
    n_cmp++;
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL parity busy_end got=%b want=0", busy_b); end
    n_cmp++;
    if (underflow[1] !== 0) begin n_bad++; $display("FAIL parity underflow got=%0d want=0", underflow[1]); end
  endtask

  task automatic test_enable_gating();
    int p0;
    en = 1'b0;
    push_byte(0, 8'h3C);
    push_byte(0, 8'hC3);
    en = 1'b1;
    #1;
    n_cmp++;
    if (ifa.fifo_rd !== 1'b1) begin n_bad++; $display("FAIL en_gate first_pop got=%b want=1", ifa.fifo_rd); end
    run_frame(0, 8'h3C, 1'b0, 9, "en_gate_3c");
    #1;
    n_cmp++;
    if (ifa.fifo_rd !== 1'b0) begin n_bad++; $display("FAIL en_gate pop_while_disabled got=%b want=0", ifa.fifo_rd); end
    expect_done_a("en_gate");
    p0 = pops[0];
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pops[0] !== p0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL en_gate held_idle pops=%0d busy=%b want pops=%0d busy=0", pops[0], busy_a, p0);
    end
    en = 1'b1;
    #1;
    n_cmp++;
    if (ifa.fifo_rd !== 1'b1) begin n_bad++; $display("FAIL en_gate reenable_pop got=%b want=1", ifa.fifo_rd); end
    run_frame(0, 8'hC3, 1'b0, -1, "en_gate_c3");
    expect_done_a("en_gate_c3");
  endtask

  task automatic test_reset_mid_frame();
    en = 1'b0;
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    en = 1'b1;
    for (int c = 0; c < 17; c++) @(negedge clk);    // cycle 16 carries data bit 3 of 0x11 = 0
    n_cmp++;
    if (tx_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid tx_before got=%b want=0", tx_a); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (tx_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid tx_async got=%b want=1", tx_a); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid busy got=%b want=0", busy_a); end
    n_cmp++;
    if (ifa.fifo_rd !== 1'b0) begin n_bad++; $display("FAIL rst_mid fifo_rd got=%b want=0", ifa.fifo_rd); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ifa.fifo_rd !== 1'b1) begin n_bad++; $display("FAIL rst_mid release_pop got=%b want=1", ifa.fifo_rd); end
    run_frame(0, 8'h22, 1'b0, -1, "rst_mid_22");
    expect_done_a("rst_mid_22");
    n_cmp++;
    if (ifa.fifo_empty !== 1'b1 || underflow[0] !== 0) begin
      n_bad++; $display("FAIL rst_mid final empty=%b underflow=%0d want empty=1 underflow=0",
                        ifa.fifo_empty, underflow[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity_two_stop();
    test_enable_gating();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit reached");
    $fatal(1, "watchdog");
  end

endmodule
